// File: rtl/uart_rx.sv
// Receiver for asynchronous serial frames.
// Frame format: 5 to 8 data bits sent LSB first, an optional even-parity
// bit, then one or two stop bits. Received words go out through a
// valid/ready handshake. Parity, framing and overrun errors are reported
// on sticky flags.
module uart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o,
  input  logic        err_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA,
    S_PARITY,
    S_STOP_BIT_FIRST,
    S_STOP_BIT_LAST
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_rxs_prev;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_perr;
  logic        r_ferr;
  logic        r_done;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_err_parity;
  logic        r_err_frame;
  logic        r_err_overrun;

  logic        w_rxs;
  logic        w_fall;
  logic        w_half;
  logic        w_sample;
  logic        w_last_bit;
  logic        w_done;
  logic        w_consume;
  logic        w_overrun;
  logic        w_start_entry;
  logic [2:0]  w_last_idx;

  assign w_rxs      = r_sync2;
  assign w_fall     = r_rxs_prev & ~w_rxs;
  // ">=" instead of "==" so that a divisor lowered mid-frame cannot leave
  // the counter stuck above its target for a full 16-bit wrap.
  assign w_half     = (r_cnt >= (cfg_div_i >> 1));
  assign w_sample   = (r_cnt >= cfg_div_i);
  assign w_last_idx = {1'b0, cfg_bits_i} + 3'd4;
  assign w_last_bit = (r_bit_cnt == w_last_idx);
  assign w_consume  = r_valid & rx_ready_i;
  assign w_overrun  = r_done & r_valid & ~w_consume;
  assign w_start_entry = (r_state == S_IDLE) && (w_next == S_START_BIT);

  assign busy_o        = (r_state != S_IDLE);
  assign rx_data_o     = r_data;
  assign rx_valid_o    = r_valid;
  assign err_parity_o  = r_err_parity;
  assign err_frame_o   = r_err_frame;
  assign err_overrun_o = r_err_overrun;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the frame-complete strobe
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    if (!cfg_en_i) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      if (w_fall) w_next = S_START_BIT;
        S_START_BIT: if (w_half) w_next = w_rxs ? S_IDLE : S_DATA;
        S_DATA:      if (w_sample && w_last_bit)
                       w_next = cfg_parity_en_i ? S_PARITY : S_STOP_BIT_FIRST;
        S_PARITY:    if (w_sample) w_next = S_STOP_BIT_FIRST;
        S_STOP_BIT_FIRST:
          if (w_sample) begin
            if (cfg_stop_bits_i) begin
              w_next = S_STOP_BIT_LAST;
            end else begin
              w_next = S_IDLE;
              w_done = 1'b1;
            end
          end
        S_STOP_BIT_LAST:
          if (w_sample) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // Synchroniser, bit timing and frame assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sync1    <= rx_i;
      r_sync2    <= r_sync1;
      r_rxs_prev <= w_rxs;
      r_done     <= w_done;

      if (r_state == S_IDLE || w_next != r_state || w_sample) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 16'd1;

      if (!cfg_en_i || r_state != S_DATA)  r_bit_cnt <= '0;
      else if (w_sample)                   r_bit_cnt <= w_last_bit ? 3'd0 : r_bit_cnt + 3'd1;

      if (w_start_entry) begin
        r_shift <= '0;
        r_par   <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end else if (cfg_en_i && w_sample) begin
        unique case (r_state)
          S_DATA: begin
            r_shift[r_bit_cnt] <= w_rxs;
            r_par              <= r_par ^ w_rxs;
          end
          S_PARITY:                          if (w_rxs != r_par) r_perr <= 1'b1;
          S_STOP_BIT_FIRST, S_STOP_BIT_LAST: if (!w_rxs)         r_ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Output word, handshake and sticky error flags (a set wins over a clear)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (r_done && (!r_valid || w_consume)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      r_err_parity  <= (r_done & r_perr) | (r_err_parity  & ~err_clr_i);
      r_err_frame   <= (r_done & r_ferr) | (r_err_frame   & ~err_clr_i);
      r_err_overrun <= w_overrun         | (r_err_overrun & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames checked against a word-level receiver model.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic        busy_o;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        cfg_parity_en_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_stop_bits_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        err_parity_o;
  logic        err_frame_o;
  logic        err_overrun_o;
  logic        err_clr_i;

  always #5 clk_i = ~clk_i;

  uart_rx dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .busy_o(busy_o),
    .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i),
    .cfg_stop_bits_i(cfg_stop_bits_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_overrun_o(err_overrun_o), .err_clr_i(err_clr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the consumer should see at word level
  logic [7:0] m_data;
  bit         m_valid, m_perr, m_ferr, m_ovr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"},   16'(rx_valid_o),    16'(m_valid));
    chk({tag, "_data"},    16'(rx_data_o),     16'(m_data));
    chk({tag, "_perr"},    16'(err_parity_o),  16'(m_perr));
    chk({tag, "_ferr"},    16'(err_frame_o),   16'(m_ferr));
    chk({tag, "_overrun"}, 16'(err_overrun_o), 16'(m_ovr));
    chk({tag, "_busy"},    16'(busy_o),        16'd0);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic line_bit(input bit v);
    rx_i = v;
    repeat (int'(cfg_div_i) + 1) @(negedge clk_i);
  endtask

  // Drive one frame using the current configuration and update the model
  task automatic send(input logic [7:0] d, input bit pbit, input bit sbit);
    int         nb;
    logic [7:0] w;
    nb = int'(cfg_bits_i) + 5;
    w  = d & 8'((1 << nb) - 1);
    line_bit(1'b0);
    for (int i = 0; i < nb; i++) line_bit(d[i]);
    if (cfg_parity_en_i) line_bit(pbit);
    line_bit(sbit);
    if (cfg_stop_bits_i) line_bit(sbit);
    if (cfg_parity_en_i && (pbit != ^w)) m_perr = 1'b1;
    if (!sbit) m_ferr = 1'b1;
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_data  = w;
    end
  endtask

  task automatic consume();
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int nb, input bit pen, input bit two_stop);
    cfg_div_i       = 16'(div);
    cfg_bits_i      = 2'(nb - 5);
    cfg_parity_en_i = pen;
    cfg_stop_bits_i = two_stop;
  endtask

  initial begin
    logic [7:0] d, mask;
    int         nb, div;
    bit         pen, pb, sb;

    rst_i = 1'b1; rx_i = 1'b1; cfg_en_i = 1'b1; rx_ready_i = 1'b0; err_clr_i = 1'b0;
    set_cfg(15, 8, 1'b0, 1'b0);
    m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_all("reset");

    // 8N1 0xA5, held, then consumed
    send(8'hA5, 1'b0, 1'b1); idle(24);
    check_all("a5");
    idle(10);
    check_all("a5_hold");
    consume();
    check_all("a5_consumed");

    // 5 bits, parity, two stop bits: correct then wrong parity
    set_cfg(15, 5, 1'b1, 1'b1);
    send(8'h13, 1'b1, 1'b1); idle(24);
    check_all("p13_ok");
    consume();
    send(8'h13, 1'b0, 1'b1); idle(24);
    check_all("p13_bad");
    consume(); clear_errs();

    // 4-cycle low glitch is a false start
    rx_i = 1'b0; repeat (4) @(negedge clk_i);
    idle(30);
    check_all("glitch");

    // Framing error then clear
    set_cfg(15, 8, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0); idle(24);
    check_all("frame_err");
    consume(); clear_errs();
    check_all("frame_clr");

    // Back-to-back frames with no consume: overrun, first word kept
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1); idle(24);
    check_all("overrun");
    consume(); clear_errs();

    // Disable mid-data, re-enable, then a clean frame
    line_bit(1'b0); line_bit(1'b1); line_bit(1'b0); line_bit(1'b1);
    cfg_en_i = 1'b0; rx_i = 1'b1;
    @(negedge clk_i);
    chk("disable_busy", 16'(busy_o), 16'd0);
    idle(5);
    cfg_en_i = 1'b1; idle(3);
    send(8'h66, 1'b0, 1'b1); idle(24);
    check_all("reenable_66");
    consume();

    // Reset mid-frame drops everything
    line_bit(1'b0); line_bit(1'b1); line_bit(1'b1);
    rst_i = 1'b1; rx_i = 1'b1; @(negedge clk_i); rst_i = 1'b0;
    m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    idle(30);
    check_all("reset_mid");

    // Randomized frames and configurations
    for (int it = 0; it < 12; it++) begin
      div = $urandom_range(3, 24);
      nb  = $urandom_range(5, 8);
      pen = 1'($urandom_range(0, 1));
      set_cfg(div, nb, pen, 1'($urandom_range(0, 1)));
      d    = 8'($urandom);
      mask = 8'((1 << nb) - 1);
      pb   = (^(d & mask)) ^ ($urandom_range(0, 3) == 0);
      sb   = ($urandom_range(0, 4) != 0);
      idle(3);
      send(d, pb, sb); idle(div + 8);
      check_all($sformatf("rand%0d", it));
      if ($urandom_range(0, 2) != 0) consume();
      if ($urandom_range(0, 1) != 0) clear_errs();
    end
    idle(3);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
